eth_phy_10g_rx_link_ctrl: RTL
=============================

# eth_phy_10g_rx_link_ctrl

Receive-side link supervisor for the 10G PHY. It sits beside the RX frame aligner and sequences it. It holds the aligner in reset, waits for block lock with a timeout, and then monitors sync-header bit-error rate over fixed windows in the style of the 802.3 clause 49 BER monitor. It forces a realignment when lock is lost for too long or high BER persists, and produces the PCS `rx_status` / `hi_ber` indications.

## Interface
Parameters:
- `HDR_WIDTH`, 2, sync-header width; fixed at 2.
- `BER_WINDOW`, 19531, BER window length in clk cycles (125 µs at 156.25 MHz).
- `BER_THRESH`, 16, invalid headers per window at or above which `hi_ber` is declared.
- `LOCK_TIMEOUT`, 4096, cycles allowed in WAIT_LOCK before realigning.
- `RESET_CYCLES`, 4, aligner reset pulse length in cycles; must be at least 1.
- `HIBER_LIMIT`, 8, consecutive high-BER windows that force a realignment.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_serdes_rx_hdr`  in  HDR_WIDTH  aligned sync header from the aligner.
- `i_hdr_valid`  in  1  qualifies `i_serdes_rx_hdr` this cycle.
- `i_rx_block_lock`  in  1  aligner lock flag, same clock domain.
- `o_aligner_rst`  out  1  active-high reset to the aligner.
- `o_rx_high_ber`  out  1  high-BER indication.
- `o_rx_status`  out  1  link usable: locked and not high BER.
- `o_ber_count`  out  6  invalid-header count of the last completed window, saturating at 63.
- `o_realign_count`  out  8  forced realignments since reset, saturating at 255.

## Operation
The state machine has three states, all outputs are registered, and the reset state is ALIGN_RST.

ALIGN_RST
- `o_aligner_rst`=1 while in this state.
- A cycle counter runs from 0 to RESET_CYCLES-1, then the FSM moves to WAIT_LOCK.
- On entry, the BER counter, window timer, high-BER streak counter and `o_rx_high_ber` are cleared.

WAIT_LOCK
- `o_aligner_rst`=0.
- The timeout counter starts at 0 on entry.
- If `i_rx_block_lock`=1, go to MONITOR.
- Otherwise, when the counter reaches LOCK_TIMEOUT-1, go to ALIGN_RST and increment `o_realign_count`.
- If lock and timeout occur in the same cycle, lock wins.

MONITOR
- If `i_rx_block_lock`=0, go to WAIT_LOCK. The timeout restarts, `o_rx_high_ber` is cleared, and the streak counter is cleared.
- The window timer counts cycles 0 to BER_WINDOW-1 and wraps.
- An invalid header is `i_hdr_valid`=1 with `i_serdes_rx_hdr` equal to 2'b00 or 2'b11. Each one increments the BER counter, saturating at 63.
- At the window-end cycle (timer = BER_WINDOW-1):
  - Update `o_ber_count` with the count including that cycle's header.
  - `o_rx_high_ber` ← (count ≥ BER_THRESH).
  - The streak counter increments if the window was high, and clears if not.
  - The BER counter restarts at 0.
- If the streak reaches HIBER_LIMIT, go to ALIGN_RST and increment `o_realign_count`.
- Loss of lock takes priority over the streak limit in the same cycle.

Other rules:
- `o_rx_status` = (state==MONITOR) && !`o_rx_high_ber`, registered.
- Headers seen outside MONITOR are ignored.
- Entering ALIGN_RST from reset does not count as a realignment.

## Timing
Reset values while `rst_n`=0:
- `o_aligner_rst`=1
- `o_rx_high_ber`=0
- `o_rx_status`=0
- `o_ber_count`=0
- `o_realign_count`=0

Latencies and cycle rules:
- After `rst_n` rises, `o_aligner_rst` stays 1 for exactly RESET_CYCLES cycles.
- Lock seen in cycle N gives state MONITOR at N+1 and `o_rx_status`=1 at N+2.
- `o_rx_high_ber` and `o_ber_count` change one cycle after the window-end cycle.
- Loss of lock in cycle N drops `o_rx_status` at N+2.
- A forced realignment asserts `o_aligner_rst` at N+1 after the deciding cycle N.
- Asserting `rst_n` mid-operation forces the reset values asynchronously.

## Test plan
Bench parameters: BER_WINDOW=64, BER_THRESH=4, LOCK_TIMEOUT=100, RESET_CYCLES=4, HIBER_LIMIT=2.

1. Release reset with lock held at 0.
   - `o_aligner_rst` is high for 4 cycles.
   - After 100 WAIT_LOCK cycles, `o_aligner_rst` pulses again and `o_realign_count`=1.
2. Raise lock 10 cycles into WAIT_LOCK and send only 2'b01 headers.
   - `o_rx_status`=1 two cycles later.
   - `o_ber_count`=0 after the first window.
3. While locked, send 3 invalid headers in one window, then 4 in the next.
   - The first window gives `o_ber_count`=3 and `hi_ber`=0.
   - The second gives `o_ber_count`=4, `hi_ber`=1 and `o_rx_status`=0.
4. Send 4 invalid headers in each of two consecutive windows.
   - After the second window end, `o_aligner_rst` pulses for 4 cycles.
   - `o_realign_count` increments and `hi_ber` clears.
5. Send 70 invalid headers, one per cycle, across a window boundary at cycle 63.
   - `o_ber_count` reports the saturated or exact window count, capped at 63.
   - The next window's count starts fresh.
6. Drop lock in the same cycle as a window end that would hit HIBER_LIMIT.
   - The FSM goes to WAIT_LOCK, not ALIGN_RST, and `o_realign_count` is unchanged.
   - Then assert `rst_n`=0 mid-window: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/eth_phy_10g_rx_link_ctrl_if.sv
// Link-control bundle between the RX frame aligner side and the link supervisor.
// The supervisor uses the slave view; whoever drives the headers and lock flag uses the master view.
interface eth_phy_10g_rx_link_ctrl_if #(
    parameter int HDR_WIDTH = 2
);
    logic [HDR_WIDTH-1:0] i_serdes_rx_hdr;
    logic                 i_hdr_valid;
    logic                 i_rx_block_lock;
    logic                 o_aligner_rst;
    logic                 o_rx_high_ber;
    logic                 o_rx_status;
    logic [5:0]           o_ber_count;
    logic [7:0]           o_realign_count;

    modport slave (
        input  i_serdes_rx_hdr,
        input  i_hdr_valid,
        input  i_rx_block_lock,
        output o_aligner_rst,
        output o_rx_high_ber,
        output o_rx_status,
        output o_ber_count,
        output o_realign_count
    );

    modport master (
        output i_serdes_rx_hdr,
        output i_hdr_valid,
        output i_rx_block_lock,
        input  o_aligner_rst,
        input  o_rx_high_ber,
        input  o_rx_status,
        input  o_ber_count,
        input  o_realign_count
    );
endinterface

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// RX link supervisor for the 10G PHY: pulses the aligner reset, waits for
// block lock with a timeout, then runs a windowed sync-header BER monitor and
// forces realignment on a persistent high-BER streak.
module eth_phy_10g_rx_link_ctrl #(
    parameter int HDR_WIDTH    = 2,
    parameter int BER_WINDOW   = 19531,
    parameter int BER_THRESH   = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int RESET_CYCLES = 4,
    parameter int HIBER_LIMIT  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    eth_phy_10g_rx_link_ctrl_if.slave  link
);

    localparam int RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int TO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int WIN_W = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
    localparam int STK_W = $clog2(HIBER_LIMIT + 1);

    localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(RESET_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(BER_WINDOW - 1);
    localparam logic [STK_W-1:0] STK_LIMIT = STK_W'(HIBER_LIMIT);
    localparam logic [6:0]       THRESH_V  = 7'(BER_THRESH);

    typedef enum logic [1:0] {
        ALIGN_RST = 2'd0,
        WAIT_LOCK = 2'd1,
        MONITOR   = 2'd2
    } state_t;

    // All-zeros or all-ones sync header is never a legal 64b/66b header.
    function automatic logic hdr_invalid(input logic [HDR_WIDTH-1:0] hdr);
        return (hdr == {HDR_WIDTH{1'b0}}) || (hdr == {HDR_WIDTH{1'b1}});
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'd255) ? v : v + 8'd1;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [RC_W-1:0]    rst_cnt_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [WIN_W-1:0]   win_cnt_r;
    logic [5:0]         ber_cnt_r;
    logic [STK_W-1:0]   streak_r;
    logic               aligner_rst_r;
    logic               hi_ber_r;
    logic               rx_status_r;
    logic [5:0]         ber_count_r;
    logic [7:0]         realign_cnt_r;

    logic               hdr_bad_s;
    logic [5:0]         ber_sum_s;
    logic               win_end_s;
    logic               win_high_s;
    logic [STK_W-1:0]   streak_nxt_s;
    logic               realign_s;
    logic               lock_loss_s;

    // BER datapath: running count including this cycle's header, window end and streak update.
    always_comb begin
        hdr_bad_s = link.i_hdr_valid && hdr_invalid(link.i_serdes_rx_hdr);
        if ((ber_cnt_r == 6'd63) || !hdr_bad_s) begin
            ber_sum_s = ber_cnt_r;
        end else begin
            ber_sum_s = ber_cnt_r + 6'd1;
        end
        win_end_s  = (win_cnt_r == WIN_LAST);
        win_high_s = ({1'b0, ber_sum_s} >= THRESH_V);
        if (!win_high_s) begin
            streak_nxt_s = {STK_W{1'b0}};
        end else if (streak_r == STK_LIMIT) begin
            streak_nxt_s = streak_r;
        end else begin
            streak_nxt_s = streak_r + STK_W'(1'b1);
        end
        lock_loss_s = (state_r == MONITOR) && !link.i_rx_block_lock;
    end

    // Next-state logic; lock beats timeout, lock loss beats the streak limit.
    always_comb begin
        state_nxt_s = state_r;
        realign_s   = 1'b0;
        case (state_r)
            ALIGN_RST: begin
                if (rst_cnt_r == RC_LAST) begin
                    state_nxt_s = WAIT_LOCK;
                end else begin
                    state_nxt_s = ALIGN_RST;
                end
            end
            WAIT_LOCK: begin
                if (link.i_rx_block_lock) begin
                    state_nxt_s = MONITOR;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s = ALIGN_RST;
                    realign_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT_LOCK;
                end
            end
            MONITOR: begin
                if (!link.i_rx_block_lock) begin
                    state_nxt_s = WAIT_LOCK;
                end else if (win_end_s && (streak_nxt_s >= STK_LIMIT)) begin
                    state_nxt_s = ALIGN_RST;
                    realign_s   = 1'b1;
                end else begin
                    state_nxt_s = MONITOR;
                end
            end
            default: begin
                state_nxt_s = ALIGN_RST;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ALIGN_RST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Reset-pulse and lock-timeout counters restart whenever their state is (re)entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_r <= {RC_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
        end else begin
            if ((state_r == ALIGN_RST) && (state_nxt_s == ALIGN_RST)) begin
                rst_cnt_r <= rst_cnt_r + RC_W'(1'b1);
            end else begin
                rst_cnt_r <= {RC_W{1'b0}};
            end
            if ((state_r == WAIT_LOCK) && (state_nxt_s == WAIT_LOCK)) begin
                to_cnt_r <= to_cnt_r + TO_W'(1'b1);
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
        end
    end

    // Window timer and running invalid-header count; only advance while monitoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r <= {WIN_W{1'b0}};
            ber_cnt_r <= 6'd0;
        end else if (realign_s) begin
            win_cnt_r <= {WIN_W{1'b0}};
            ber_cnt_r <= 6'd0;
        end else if (state_r == MONITOR) begin
            if (win_end_s) begin
                win_cnt_r <= {WIN_W{1'b0}};
                ber_cnt_r <= 6'd0;
            end else begin
                win_cnt_r <= win_cnt_r + WIN_W'(1'b1);
                ber_cnt_r <= ber_sum_s;
            end
        end else begin
            win_cnt_r <= win_cnt_r;
            ber_cnt_r <= ber_cnt_r;
        end
    end

    // Per-window results: reported count, high-BER flag and high-window streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ber_count_r <= 6'd0;
            hi_ber_r    <= 1'b0;
            streak_r    <= {STK_W{1'b0}};
        end else begin
            if ((state_r == MONITOR) && win_end_s) begin
                ber_count_r <= ber_sum_s;
            end else begin
                ber_count_r <= ber_count_r;
            end
            if (realign_s || lock_loss_s) begin
                hi_ber_r <= 1'b0;
                streak_r <= {STK_W{1'b0}};
            end else if ((state_r == MONITOR) && win_end_s) begin
                hi_ber_r <= win_high_s;
                streak_r <= streak_nxt_s;
            end else begin
                hi_ber_r <= hi_ber_r;
                streak_r <= streak_r;
            end
        end
    end

    // Registered status outputs and the forced-realignment counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aligner_rst_r <= 1'b1;
            rx_status_r   <= 1'b0;
            realign_cnt_r <= 8'd0;
        end else begin
            aligner_rst_r <= (state_nxt_s == ALIGN_RST);
            rx_status_r   <= (state_r == MONITOR) && !hi_ber_r;
            if (realign_s) begin
                realign_cnt_r <= sat_inc8(realign_cnt_r);
            end else begin
                realign_cnt_r <= realign_cnt_r;
            end
        end
    end

    assign link.o_aligner_rst   = aligner_rst_r;
    assign link.o_rx_high_ber   = hi_ber_r;
    assign link.o_rx_status     = rx_status_r;
    assign link.o_ber_count     = ber_count_r;
    assign link.o_realign_count = realign_cnt_r;

endmodule
